// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and widths for the program loader and CPU fetch.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int BYTE_W     = 8;
    localparam int ADDR_W     = $clog2(IMEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// ============================================================================
// Module      : loader_timeout
// Description : Saturating idle-cycle counter; flags the TIMEOUT-th idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module loader_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the idle cycle whose closing edge would make the count TIMEOUT.
    assign expired = enable && !clear && (count_q >= LAST);

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Streams a LEN/payload/CSUM image into instruction memory and
//               holds the CPU in reset until the image verifies.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
    parameter int                TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    loader_state_t     state_q, state_d;
    logic [BYTE_W-1:0] cnt_q, cnt_d;
    logic [BYTE_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [BYTE_W-1:0] wdata_q, wdata_d;

    logic beat;
    logic load_start;
    logic tmo_expired;

    assign in_ready   = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign beat       = in_valid && in_ready;
    assign load_start = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (beat || load_start),
        .enable  (in_ready && !beat),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (beat) begin
                    state_d = DATA;
                    // LEN of zero wraps to 255, i.e. 256 bytes remaining.
                    cnt_d   = in_data - 8'd1;
                    addr_d  = BASE_ADDR;
                    sum_d   = '0;
                end else if (tmo_expired) begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (beat) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    sum_d   = sum_q + in_data;
                    addr_d  = addr_q + 8'd1;
                    if (cnt_q == '0) begin
                        state_d = CSUM;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else if (tmo_expired) begin
                    state_d = ERR;
                end
            end
            CSUM: begin
                if (beat) begin
                    state_d = (in_data == sum_q) ? DONE : ERR;
                end else if (tmo_expired) begin
                    state_d = ERR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            addr_q  <= BASE_ADDR;
            we_q    <= 1'b0;
            waddr_q <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = (state_q != DONE);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Randomised self-checking bench; two loaders (base 00 and F0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int TO = 20;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic       rdy0, we0, hold0, done0, err0;
    logic       rdy1, we1, hold1, done1, err1;
    logic [7:0] addr0, wd0, addr1, wd1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    wr_t        wq0[$];
    wr_t        wq1[$];
    logic [7:0] payload[$];

    program_loader #(.BASE_ADDR(8'h00), .TIMEOUT(TO)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .cpu_hold(hold0), .done(done0), .error(err0)
    );

    program_loader #(.BASE_ADDR(8'hF0), .TIMEOUT(TO)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .cpu_hold(hold1), .done(done1), .error(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (we0 === 1'b1) wq0.push_back('{a: addr0, d: wd0, c: cyc});
        if (we1 === 1'b1) wq1.push_back('{a: addr1, d: wd1, c: cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // LEN, payload, then checksum (xor-corrupted when csum_xor != 0).
    task automatic drive_stream(input int maxgap, input logic [7:0] csum_xor);
        int s;
        s = 0;
        send_byte(8'(payload.size()), maxgap);
        foreach (payload[i]) begin
            send_byte(payload[i], int'($urandom_range(0, maxgap)));
            s += int'(payload[i]);
        end
        send_byte(8'(s) ^ csum_xor, int'($urandom_range(0, maxgap)));
    endtask

    task automatic rand_payload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rdy1, rdy0, we1, we0, done1, done0, err1, err0} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000000", {rdy1, rdy0, we1, we0, done1, done0, err1, err0});
        end
        checks++;
        if ({hold1, hold0} !== 2'b11) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=11", {hold1, hold0});
        end
        checks++;
        if (addr0 !== 8'h00 || addr1 !== 8'hF0 || wd0 !== 8'h00 || wd1 !== 8'h00) begin
            failures++;
            $display("FAIL reset_mem got=%h/%h %h/%h exp=00/00 f0/00", addr0, wd0, addr1, wd1);
        end
        reset = 1'b0;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        checks++;
        if ({rdy1, rdy0} !== 2'b00 || wq0.size() != 0 || wq1.size() != 0) begin
            failures++;
            $display("FAIL idle_accept rdy=%b writes=%0d/%0d exp rdy=00 writes=0", {rdy1, rdy0}, wq0.size(), wq1.size());
        end
    endtask

    task automatic test_basic();
        wq0.delete(); wq1.delete();
        payload = '{8'h11, 8'h22, 8'h33};
        pulse_start();
        checks++;
        if ({rdy1, rdy0, hold1, hold0} !== 4'b1111) begin
            failures++;
            $display("FAIL basic_start got=%b exp=1111", {rdy1, rdy0, hold1, hold0});
        end
        drive_stream(0, 8'h00);
        for (int u = 0; u < 2; u++) begin
            wr_t        q[$];
            logic [7:0] base;
            if (u == 0) begin q = wq0; base = 8'h00; end else begin q = wq1; base = 8'hF0; end
            checks++;
            if (q.size() != 3) begin
                failures++;
                $display("FAIL basic_count dut%0d got=%0d exp=3", u, q.size());
            end else for (int i = 0; i < 3; i++) begin
                checks++;
                if (q[i].a !== base + 8'(i) || q[i].d !== payload[i] || q[i].c !== q[0].c + i) begin
                    failures++;
                    $display("FAIL basic_write dut%0d i=%0d got=%h:%h@%0d exp=%h:%h@%0d",
                             u, i, q[i].a, q[i].d, q[i].c, base + 8'(i), payload[i], q[0].c + i);
                end
            end
        end
        checks++;
        if ({done1, done0, hold1, hold0, err1, err0} !== 6'b110000) begin
            failures++;
            $display("FAIL basic_done got=%b exp=110000", {done1, done0, hold1, hold0, err1, err0});
        end
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        checks++;
        if ({rdy1, rdy0} !== 2'b00 || wq0.size() != 3 || wq1.size() != 3 || {done1, done0} !== 2'b11) begin
            failures++;
            $display("FAIL done_idle rdy=%b writes=%0d/%0d done=%b exp rdy=00 writes=3 done=11",
                     {rdy1, rdy0}, wq0.size(), wq1.size(), {done1, done0});
        end
    endtask

    task automatic test_bad_csum();
        wq0.delete(); wq1.delete();
        payload = '{8'h0A, 8'h0B};
        pulse_start();
        checks++;
        if ({hold1, hold0, done1, done0, rdy1, rdy0} !== 6'b110011) begin
            failures++;
            $display("FAIL restart_done got=%b exp=110011", {hold1, hold0, done1, done0, rdy1, rdy0});
        end
        drive_stream(0, 8'h15);
        checks++;
        if (wq0.size() != 2 || wq1.size() != 2 || wq0[0].d !== 8'h0A || wq1[1].a !== 8'hF1) begin
            failures++;
            $display("FAIL badcs_writes got=%0d/%0d exp=2/2", wq0.size(), wq1.size());
        end
        checks++;
        if ({err1, err0, hold1, hold0, done1, done0} !== 6'b111100) begin
            failures++;
            $display("FAIL badcs_status got=%b exp=111100", {err1, err0, hold1, hold0, done1, done0});
        end
    endtask

    task automatic test_full_wrap();
        wq0.delete(); wq1.delete();
        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'(i));
        pulse_start();
        checks++;
        if ({err1, err0, hold1, hold0, rdy1, rdy0} !== 6'b001111) begin
            failures++;
            $display("FAIL restart_err got=%b exp=001111", {err1, err0, hold1, hold0, rdy1, rdy0});
        end
        drive_stream(0, 8'h00);
        for (int u = 0; u < 2; u++) begin
            wr_t        q[$];
            logic [7:0] base;
            int         bad;
            if (u == 0) begin q = wq0; base = 8'h00; end else begin q = wq1; base = 8'hF0; end
            bad = 0;
            checks++;
            if (q.size() != 256) begin
                failures++;
                $display("FAIL wrap_count dut%0d got=%0d exp=256", u, q.size());
            end else for (int i = 0; i < 256; i++) begin
                if (q[i].a !== base + 8'(i) || q[i].d !== 8'(i)) begin
                    if (bad == 0)
                        $display("FAIL wrap_write dut%0d i=%0d got=%h:%h exp=%h:%h", u, i, q[i].a, q[i].d, base + 8'(i), 8'(i));
                    bad++;
                end
            end
            checks++;
            if (bad != 0) failures++;
        end
        checks++;
        if ({done1, done0, hold1, hold0, err1, err0} !== 6'b110000) begin
            failures++;
            $display("FAIL wrap_done got=%b exp=110000", {done1, done0, hold1, hold0, err1, err0});
        end
    endtask

    task automatic test_stalls();
        for (int it = 0; it < 3; it++) begin
            wq0.delete(); wq1.delete();
            rand_payload(int'($urandom_range(1, 40)));
            pulse_start();
            drive_stream(TO - 1, 8'h00);
            for (int u = 0; u < 2; u++) begin
                wr_t        q[$];
                logic [7:0] base;
                int         bad;
                if (u == 0) begin q = wq0; base = 8'h00; end else begin q = wq1; base = 8'hF0; end
                bad = 0;
                checks++;
                if (q.size() != payload.size()) begin
                    bad++;
                    $display("FAIL stall_count dut%0d got=%0d exp=%0d", u, q.size(), payload.size());
                end else for (int i = 0; i < q.size(); i++) begin
                    if (q[i].a !== base + 8'(i) || q[i].d !== payload[i]) begin
                        if (bad == 0)
                            $display("FAIL stall_write dut%0d i=%0d got=%h:%h exp=%h:%h", u, i, q[i].a, q[i].d, base + 8'(i), payload[i]);
                        bad++;
                    end
                end
                if (bad != 0) failures++;
            end
            checks++;
            if ({done1, done0, err1, err0} !== 4'b1100) begin
                failures++;
                $display("FAIL stall_done it=%0d got=%b exp=1100", it, {done1, done0, err1, err0});
            end
        end
    endtask

    task automatic test_timeout();
        for (int ph = 0; ph < 3; ph++) begin
            pulse_start();
            if (ph >= 1) send_byte(8'h04, 0);
            if (ph >= 2) send_byte(8'hA5, 0);
            repeat (TO - 1) tick();
            checks++;
            if ({err1, err0, rdy1, rdy0} !== 4'b0011) begin
                failures++;
                $display("FAIL timeout_early ph=%0d got=%b exp=0011", ph, {err1, err0, rdy1, rdy0});
            end
            tick();
            checks++;
            if ({err1, err0, hold1, hold0, rdy1, rdy0, done1, done0} !== 8'b11110000) begin
                failures++;
                $display("FAIL timeout_fire ph=%0d got=%b exp=11110000", ph, {err1, err0, hold1, hold0, rdy1, rdy0, done1, done0});
            end
        end
    endtask

    task automatic test_midload_reset();
        pulse_start();
        send_byte(8'h05, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hC3, 0);
        reset = 1'b1;
        tick();
        checks++;
        if ({rdy1, rdy0, hold1, hold0, we1, we0, done1, done0, err1, err0} !== 10'b0011000000) begin
            failures++;
            $display("FAIL midreset got=%b exp=0011000000", {rdy1, rdy0, hold1, hold0, we1, we0, done1, done0, err1, err0});
        end
        reset = 1'b0;
        tick();
        wq0.delete(); wq1.delete();
        rand_payload(5);
        pulse_start();
        drive_stream(3, 8'h00);
        checks++;
        if (wq0.size() != 5 || wq1.size() != 5 || wq0[4].a !== 8'h04 || wq1[4].a !== 8'hF4 ||
            wq0[2].d !== payload[2] || wq1[3].d !== payload[3]) begin
            failures++;
            $display("FAIL midreset_reload writes=%0d/%0d exp=5/5", wq0.size(), wq1.size());
        end
        checks++;
        if ({done1, done0, hold1, hold0} !== 4'b1100) begin
            failures++;
            $display("FAIL midreset_done got=%b exp=1100", {done1, done0, hold1, hold0});
        end
    endtask

    task automatic test_restart_ignore();
        int s;
        wq0.delete(); wq1.delete();
        rand_payload(6);
        pulse_start();
        checks++;
        if ({hold1, hold0, done1, done0, rdy1, rdy0} !== 6'b110011) begin
            failures++;
            $display("FAIL restart2 got=%b exp=110011", {hold1, hold0, done1, done0, rdy1, rdy0});
        end
        s = 0;
        foreach (payload[i]) s += int'(payload[i]);
        send_byte(8'd6, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) start = 1'b1;
            send_byte(payload[i], 0);
            start = 1'b0;
            if (i == 3) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        send_byte(8'(s), 0);
        checks++;
        if (wq0.size() != 6 || wq1.size() != 6) begin
            failures++;
            $display("FAIL ignore_count got=%0d/%0d exp=6/6", wq0.size(), wq1.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wq0[i].a !== 8'(i) || wq1[i].a !== 8'hF0 + 8'(i) || wq0[i].d !== payload[i] || wq1[i].d !== payload[i]) begin
                    failures++;
                    $display("FAIL ignore_write i=%0d got=%h:%h %h:%h exp=%h:%h %h:%h", i, wq0[i].a, wq0[i].d,
                             wq1[i].a, wq1[i].d, 8'(i), payload[i], 8'hF0 + 8'(i), payload[i]);
                end
            end
        end
        checks++;
        if ({done1, done0, hold1, hold0, err1, err0} !== 6'b110000) begin
            failures++;
            $display("FAIL ignore_done got=%b exp=110000", {done1, done0, hold1, hold0, err1, err0});
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_bad_csum();
        test_full_wrap();
        test_stalls();
        test_timeout();
        test_midload_reset();
        test_restart_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Writes a program image into the CPU's 256×8 instruction memory from a byte stream, and holds the CPU in reset until the image is complete and its checksum verifies. It sits between the host/serial byte source and the memory write port. The CPU fetch path only reads the same memory; this block is its only writer.

## Interface
- `BASE_ADDR`, default 8'h00: first memory address written. Addresses wrap modulo 256.
- `TIMEOUT`, default 1024: maximum idle cycles allowed between accepted beats while loading. Must be ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `mem_we`  out  1  write strobe to instruction memory.
- `mem_addr`  out  8  write address.
- `mem_wdata`  out  8  write data.
- `cpu_hold`  out  1  drives the CPU reset; 1 = CPU held.
- `done`  out  1  image loaded and checksum verified; level signal.
- `error`  out  1  checksum mismatch or timeout; level signal.

## Operation
- **Stream format:** LEN byte, then payload bytes, then CSUM byte.
  - Payload length N = LEN; LEN = 0 means N = 256.
  - CSUM = (sum of payload bytes) mod 256.
- **Beat:** a beat transfers when `in_valid && in_ready`. `in_ready` is a pure function of state: 1 in LEN, DATA and CSUM; 0 otherwise. The source may drop `in_valid` at any time.
- **FSM states:** IDLE, LEN, DATA, CSUM, DONE, ERR.
  - IDLE –start→ LEN.
  - LEN –beat→ DATA. On this beat: cnt ← N−1, addr ← BASE_ADDR, sum ← 0.
  - DATA –beat→ write the byte, sum += byte, addr += 1 (8-bit wrap). If cnt == 0 go to CSUM; else cnt −= 1.
  - CSUM –beat→ DONE if byte == sum, else ERR.
  - LEN, DATA or CSUM → ERR when the idle counter reaches TIMEOUT.
  - DONE or ERR –start→ LEN. `done`/`error` clear and `cpu_hold` reasserts on the same edge that enters LEN.
- **Counter widths:** cnt is 8 bits (0..255 encodes 1..256 remaining). sum is 8-bit modular.
- **Idle counter:**
  - Cleared on entry to LEN and on every beat.
  - Increments each cycle in LEN/DATA/CSUM when no beat occurs.
  - Saturates at TIMEOUT.
- **Reset values:** `cpu_hold`=1, `done`=0, `error`=0, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, state=IDLE.
  - `reset` mid-load aborts immediately. Memory contents already written are left as-is.
- **Output levels by state:** `cpu_hold`=0 only in DONE. `done`=1 only in DONE. `error`=1 only in ERR.
- **start during a load:** ignored while in LEN, DATA or CSUM.

## Timing
- **Write latency:** `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - A payload beat accepted at edge k produces `mem_we`=1 for exactly the one cycle after edge k.
  - That cycle shows the byte's address and data.
  - Back-to-back beats produce back-to-back writes at consecutive addresses.
- **Release latency:** the CSUM beat at edge k sets `done`=1 and `cpu_hold`=0 after edge k.
  - The last payload write happens at least one cycle before release, so the CPU never fetches unwritten data.
- **start latency:** `start` at edge k puts the block in LEN after edge k, so `in_ready`=1 in the following cycle.
- **Timeout:** with no beat for TIMEOUT consecutive cycles, `error`=1 after the TIMEOUT-th idle edge.
- **Wrap:** with BASE_ADDR=8'hF0 and N=32, addresses go F0..FF then 00..0F.

## Structure
- **Shared package `loader_pkg`:**
  - State enum `loader_state_t` (IDLE, LEN, DATA, CSUM, DONE, ERR).
  - Constant `IMEM_DEPTH`=256.
  - Byte/address width constants, shared with the CPU fetch path.
- **Sub-module `loader_timeout`:**
  - Ports: `clk`, `reset`, `clear`, `enable`, `expired`.
  - Parameterised by TIMEOUT; the counter width is derived from TIMEOUT.
- **Top level:** FSM, cnt, sum and the output registers live in `program_loader`.

## Test plan
- **Basic load:** reset, start, stream {03, 11, 22, 33, 66}, `in_valid` held high.
  - Writes (00,11), (01,22), (02,33) on consecutive cycles.
  - Then `done`=1, `cpu_hold`=0, `error`=0.
- **Bad checksum:** stream {02, 0A, 0B, 00}.
  - Two writes occur, then `error`=1, `cpu_hold` stays 1, `done`=0.
- **Full image with wrap:** BASE_ADDR=F0, LEN=00 (256 bytes), payload byte i = i, CSUM=80.
  - Exactly 256 writes covering F0..FF then 00..EF, then `done`=1.
- **Stalls and timeout:** random `in_valid` gaps shorter than TIMEOUT complete normally, with addresses unchanged across gaps.
  - A gap of exactly TIMEOUT cycles after the LEN byte gives `error`=1.
- **Mid-load reset:** `reset` after 2 of 5 payload bytes.
  - Next cycle: state IDLE, `in_ready`=0, `cpu_hold`=1, `mem_we`=0.
  - A following start plus a full stream loads correctly.
- **Restart from DONE:** after a successful load, pulse start.
  - `cpu_hold`=1 and `done`=0 the next cycle; a second image loads.
  - start pulsed during DATA is ignored.
